// File: rtl/interrupt_claim_complete.sv
// Claim/complete unit: gateways, best-ID selection and bus access
// to the pending words and claim/complete register.
module interrupt_claim_complete #(
  parameter int N_interrupts = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [N_interrupts-1:0]   interrupt_requests,
  input  logic [N_interrupts-1:0]   interrupt_masks,
  input  logic [32*N_interrupts-1:0] interrupt_priority_regs,
  input  logic [31:0]               pending_addr,
  input  logic [31:0]               claim_complete_addr,
  input  logic [31:0]               addr,
  input  logic                      ren,
  input  logic                      wen,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      addr_valid,
  output logic                      interrupt_service_request
);

  localparam int IW = $clog2(N_interrupts + 1);
  localparam int NW = (N_interrupts + 32) / 32;
  localparam int PW = NW * 32;

  logic [N_interrupts-1:0] pending;
  logic [N_interrupts-1:0] in_service;
  logic [N_interrupts-1:0] claim_vec;
  logic [N_interrupts-1:0] done_vec;
  logic [N_interrupts-1:0] eligible;
  logic [IW-1:0]           best_id;
  logic [IW-1:0]           best_nxt;
  logic [31:0]             best_prio;
  logic                    found;
  logic [PW-1:0]           pend_flat;
  logic [31:0]             offset;
  logic                    cc_hit;
  logic                    pend_hit;
  logic                    claim;
  logic                    complete_wr;

  assign cc_hit      = (addr == claim_complete_addr);
  assign offset      = addr - pending_addr;
  assign pend_hit    = (offset < 32'(4 * NW));
  assign addr_valid  = cc_hit | pend_hit;
  assign claim       = ren & cc_hit & (best_id != '0);
  assign complete_wr = wen & cc_hit;

  assign interrupt_service_request = (best_id != '0);

  always_comb begin
    claim_vec = '0;
    done_vec  = '0;
    for (int i = 0; i < N_interrupts; i++) begin
      claim_vec[i] = claim && (best_id == IW'(i + 1));
      done_vec[i]  = complete_wr && (wdata == 32'(i + 1))
                     && in_service[i];
    end
  end

  // The source being claimed this cycle must not win again next cycle.
  assign eligible = pending & ~interrupt_masks & ~claim_vec;

  always_comb begin
    best_nxt  = '0;
    best_prio = '0;
    found     = 1'b0;
    for (int i = 0; i < N_interrupts; i++) begin
      if (eligible[i] && (!found ||
          interrupt_priority_regs[i*32 +: 32] > best_prio)) begin
        found     = 1'b1;
        best_prio = interrupt_priority_regs[i*32 +: 32];
        best_nxt  = IW'(i + 1);
      end
    end
  end

  always_comb begin
    pend_flat                 = '0;
    pend_flat[N_interrupts:1] = pending;
  end

  always_comb begin
    rdata = '0;
    if (cc_hit) begin
      rdata = 32'(best_id);
    end else if (pend_hit) begin
      for (int k = 0; k < NW; k++) begin
        if (offset >= 32'(4 * k) && offset < 32'(4 * k + 4))
          rdata = pend_flat[k*32 +: 32];
      end
    end
  end

  // Gateway uses the old in_service, so a completion re-pends one edge later.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending    <= '0;
      in_service <= '0;
      best_id    <= '0;
    end else begin
      pending    <= (pending & ~claim_vec)
                  | (interrupt_requests & ~pending & ~in_service);
      in_service <= (in_service & ~done_vec) | claim_vec;
      best_id    <= best_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_claim_complete.sv
// Directed bench for interrupt_claim_complete.
// Hand-computed expectations for claim/complete/pending behaviour.
module tb_interrupt_claim_complete;

  localparam int N = 32;
  localparam logic [31:0] PEND = 32'h0000_1000;
  localparam logic [31:0] PW1  = 32'h0000_1004;
  localparam logic [31:0] UNM  = 32'h0000_1008;
  localparam logic [31:0] CC   = 32'h0000_2000;

  logic          clk;
  logic          n_rst;
  logic [N-1:0]  req;
  logic [N-1:0]  masks;
  logic [32*N-1:0] prio;
  logic [31:0]   addr;
  logic          ren;
  logic          wen;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          addr_valid;
  logic          isr;
  logic [31:0]   d;

  int n_checks;
  int n_errors;

  interrupt_claim_complete #(.N_interrupts(N)) dut (
    .clk                       (clk),
    .n_rst                     (n_rst),
    .interrupt_requests        (req),
    .interrupt_masks           (masks),
    .interrupt_priority_regs   (prio),
    .pending_addr              (PEND),
    .claim_complete_addr       (CC),
    .addr                      (addr),
    .ren                       (ren),
    .wen                       (wen),
    .wdata                     (wdata),
    .rdata                     (rdata),
    .addr_valid                (addr_valid),
    .interrupt_service_request (isr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    ren  = 1'b1;
    #1;
    v = rdata;
    step();
    ren  = 1'b0;
    addr = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    addr  = a;
    wdata = v;
    wen   = 1'b1;
    step();
    wen   = 1'b0;
    addr  = 32'h0;
  endtask

  task automatic set_prio(input int id, input logic [31:0] p);
    prio[(id-1)*32 +: 32] = p;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst = 1'b0;
    req   = '0;
    masks = '0;
    prio  = '0;
    addr  = 32'h0;
    ren   = 1'b0;
    wen   = 1'b0;
    wdata = 32'h0;
    for (int i = 1; i <= N; i++) set_prio(i, 32'd5);

    #12;
    check("rst_isr", 32'(isr), 32'd0);
    peek(CC, d);
    check("rst_claim", d, 32'd0);
    n_rst = 1'b1;
    step();

    // ID 3 request -> pending -> service request -> claim
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    peek(PEND, d);
    check("id3_pending", d, 32'd8);
    check("id3_isr_lat", 32'(isr), 32'd0);
    step();
    check("id3_isr", 32'(isr), 32'd1);
    bus_read(CC, d);
    check("id3_claim", d, 32'd3);
    check("id3_isr_drop", 32'(isr), 32'd0);
    bus_write(CC, 32'd3);
    peek(PEND, d);
    check("id3_clear", d, 32'd0);

    // Equal priority tie, then exhausted
    set_prio(2, 32'd7);
    set_prio(5, 32'd7);
    req[1] = 1'b1;
    req[4] = 1'b1;
    step();
    req[1] = 1'b0;
    req[4] = 1'b0;
    step();
    bus_read(CC, d);
    check("tie_first", d, 32'd2);
    bus_read(CC, d);
    check("tie_second", d, 32'd5);
    bus_read(CC, d);
    check("tie_none", d, 32'd0);
    check("tie_isr", 32'(isr), 32'd0);
    bus_write(CC, 32'd2);
    bus_write(CC, 32'd5);

    // Full 32-bit unsigned compare, priority 0 still eligible
    set_prio(9, 32'h7FFF_FFFF);
    set_prio(10, 32'h8000_0000);
    set_prio(3, 32'h0);
    req[8] = 1'b1;
    req[9] = 1'b1;
    req[2] = 1'b1;
    step();
    req[8] = 1'b0;
    req[9] = 1'b0;
    req[2] = 1'b0;
    step();
    bus_read(CC, d);
    check("prio_msb", d, 32'd10);
    bus_read(CC, d);
    check("prio_next", d, 32'd9);
    bus_read(CC, d);
    check("prio_zero", d, 32'd3);
    bus_write(CC, 32'd10);
    bus_write(CC, 32'd9);
    bus_write(CC, 32'd3);

    // ID 4 held high: no re-pend until completed
    req[3] = 1'b1;
    step();
    step();
    bus_read(CC, d);
    check("id4_claim", d, 32'd4);
    step();
    peek(PEND, d);
    check("id4_no_repend", d, 32'd0);
    check("id4_isr", 32'(isr), 32'd0);
    bus_write(CC, 32'd4);
    peek(PEND, d);
    check("id4_same_edge", d, 32'd0);
    step();
    peek(PEND, d);
    check("id4_repend", d, 32'd16);
    req[3] = 1'b0;
    step();
    bus_read(CC, d);
    check("id4_reclaim", d, 32'd4);
    bus_write(CC, 32'd4);

    // Masked ID 1 stays pending, eligible after unmask
    masks[0] = 1'b1;
    req[0]   = 1'b1;
    step();
    req[0] = 1'b0;
    step();
    check("mask_isr", 32'(isr), 32'd0);
    bus_read(CC, d);
    check("mask_claim", d, 32'd0);
    peek(PEND, d);
    check("mask_pending", d, 32'd2);
    masks[0] = 1'b0;
    step();
    check("unmask_isr", 32'(isr), 32'd1);
    bus_read(CC, d);
    check("unmask_claim", d, 32'd1);
    bus_write(CC, 32'd1);

    // Window decode and ignored pending writes
    peek(UNM, d);
    check("unmapped_data", d, 32'd0);
    check("unmapped_valid", 32'(addr_valid), 32'd0);
    peek(PW1, d);
    check("word1_data", d, 32'd0);
    check("word1_valid", 32'(addr_valid), 32'd1);
    bus_write(PEND, 32'hFFFF_FFFF);
    peek(PEND, d);
    check("pend_wr_ignored", d, 32'd0);
    masks[31] = 1'b1;
    req[31]   = 1'b1;
    step();
    req[31] = 1'b0;
    peek(PW1, d);
    check("word1_id32", d, 32'd1);

    // Invalid completes leave ID 8 in service
    req[7]   = 1'b1;
    masks[5] = 1'b1;
    req[5]   = 1'b1;
    step();
    req[5] = 1'b0;
    step();
    bus_read(CC, d);
    check("id8_claim", d, 32'd8);
    bus_write(CC, 32'd0);
    bus_write(CC, 32'd33);
    bus_write(CC, 32'd6);
    step();
    peek(PEND, d);
    check("bad_complete", d, 32'd64);
    bus_write(CC, 32'd8);
    step();
    peek(PEND, d);
    check("good_complete", d, 32'd320);

    // Clean slate
    req[7] = 1'b0;
    masks  = '0;
    n_rst  = 1'b0;
    #2;
    n_rst = 1'b1;
    step();
    peek(PEND, d);
    check("clean_w0", d, 32'd0);
    peek(PW1, d);
    check("clean_w1", d, 32'd0);

    // Reset with ID 2 in service and ID 7 pending
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    step();
    bus_read(CC, d);
    check("pre_rst_claim", d, 32'd2);
    masks[6] = 1'b1;
    req[6]   = 1'b1;
    step();
    peek(PEND, d);
    check("pre_rst_pend", d, 32'd128);
    n_rst = 1'b0;
    #1;
    check("rst_isr_now", 32'(isr), 32'd0);
    peek(CC, d);
    check("rst_claim_now", d, 32'd0);
    peek(PEND, d);
    check("rst_pend_now", d, 32'd0);
    n_rst = 1'b1;
    step();
    peek(PEND, d);
    check("post_rst_repend", d, 32'd128);
    masks[6] = 1'b0;
    step();
    check("post_rst_isr", 32'(isr), 32'd1);
    bus_read(CC, d);
    check("post_rst_claim", d, 32'd7);
    req[6] = 1'b0;
    bus_write(CC, 32'd7);
    req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    peek(PEND, d);
    check("id2_svc_dropped", d, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
